nf10_upb_packet_arbiter: RTL and testbench
==========================================

// Module: nf10_upb_packet_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter. Merges C_NUM_INPUTS AXI4-Stream arbiter
//  streams from the nf10_upb_10g_input modules into one stream toward the switch pipeline.
//  Carries the 256-bit data and the full tuser sideband
//  (packet_length, in_port, out_port, in_vport, out_vport) unmodified.
//  Never interleaves beats of different packets.
// PARAMETERS
//  C_NUM_INPUTS           4    number of requesting input streams (1..8)
//  C_AXIS_DATA_WIDTH      256  tdata width; tkeep is C_AXIS_DATA_WIDTH/8
//  C_PACKET_LENGTH_WIDTH  14   tuser packet_length width
//  C_INPORT_WIDTH         3    tuser in_port / in_vport width
//  C_OUTPORT_WIDTH        8    tuser out_port / out_vport width
// PORTS  (s_* buses are flattened; input i occupies slice i)
//  axi_aclk                    in   1      sole clock
//  axi_resetn                  in   1      asynchronous reset, active-low
//  s_axis_tdata                in   N*DW   per-input data
//  s_axis_tkeep                in   N*DW/8 per-input byte enables
//  s_axis_tuser_packet_length  in   N*PLW  per-input packet length (bytes)
//  s_axis_tuser_in_port        in   N*IPW  per-input physical ingress port
//  s_axis_tuser_out_port       in   N*OPW  per-input egress port bitmap
//  s_axis_tuser_in_vport       in   N*IPW  per-input virtual ingress port
//  s_axis_tuser_out_vport      in   N*OPW  per-input virtual egress bitmap
//  s_axis_tvalid               in   N      per-input valid
//  s_axis_tready               out  N      per-input ready
//  s_axis_tlast                in   N      per-input end of packet
//  m_axis_tdata/tkeep/tuser_*  out  as above, single stream
//  m_axis_tvalid               out  1      merged valid
//  m_axis_tready               in   1      downstream ready
//  m_axis_tlast                out  1      merged end of packet
//  grant_valid                 out  1      a packet is currently granted
//  grant_port                  out  3      index of granted input (debug/stats)
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE. last_grant = C_NUM_INPUTS-1, so input 0 wins first.
//   Register slice is emptied. Reset mid-packet abandons the partial packet without completing it.
//  FSM:
//   IDLE: if any s_axis_tvalid, grant = first valid index searching
//    last_grant+1, +2, ... modulo C_NUM_INPUTS. Register grant, set grant_valid, -> XFER.
//    All s_axis_tready = 0 in IDLE.
//   XFER: s_axis_tready[grant] = slice ready. All other tready = 0.
//    Beat accepted when s_axis_tvalid[grant] && s_axis_tready[grant].
//    When the accepted beat has tlast: last_grant <= grant, grant_valid <= 0, -> IDLE.
//  Arbitration bubble: exactly 1 idle input cycle between a tlast acceptance and the next grant.
//  Latency: first beat of a granted packet is on m_axis 2 cycles after the IDLE cycle
//   that sees tvalid (grant cycle + slice register).
//  Throughput: 1 beat/cycle within a packet while m_axis_tready=1.
//  Granted input deasserts tvalid mid-packet: grant is held indefinitely and no other
//   input is served. The output idles (m_axis_tvalid=0). No timeout.
//  Output AXI rules: once m_axis_tvalid=1, m_axis_tdata/tkeep/tuser/tlast are stable
//   until the handshake completes. tvalid is never retracted.
//  Non-granted inputs are never acknowledged, and their data is ignored.
//  tuser fields are sampled with every beat and passed through unchanged; no recomputation.
//  C_NUM_INPUTS=1: degenerates to register slice plus 1-cycle bubble per packet.
// STRUCTURE
//  Shared package nf10_upb_pkg: state encoding (IDLE, XFER) and default widths
//   for packet_length, in_port and out_port, which are shared with the input and output modules.
//  Round-robin next-index function lives in the package as a function.
//  Sub-module nf10_upb_axis_reg_slice: 2-entry full-throughput skid buffer.
//   Width = DW + DW/8 + PLW + 2*IPW + 2*OPW + 1. Registered tready toward the mux.
// TESTING
//  1 All 4 inputs send one 3-beat packet simultaneously, m_tready=1
//     -> output order 0,1,2,3. 12 beats, one bubble between packets, tuser intact.
//  2 Input 2 streams 5 packets back-to-back, others idle
//     -> all 5 packets forwarded in order. grant_port=2 throughout.
//  3 Inputs 1 and 3 valid, last_grant=1
//     -> grant goes to 3, then 1. Never 1 twice while 3 is waiting.
//  4 m_tready toggles 1010... during a 64-beat packet
//     -> no beat lost or duplicated, and output stays stable while stalled.
//  5 Granted input drops tvalid for 10 cycles mid-packet while input 0 is valid
//     -> input 0 gets tready=0 throughout, and the granted packet completes first.
//  6 axi_resetn pulsed low during beat 2 of 4
//     -> m_axis_tvalid=0 next edge, grant_valid=0, and the first grant after reset is input 0.

Source files
------------

// File: rtl/nf10_upb_pkg.sv
// Shared definitions for the nf10_upb datapath: arbiter state encoding,
// default sideband widths and the round-robin search helper.
package nf10_upb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   localparam int C_DEF_PACKET_LENGTH_WIDTH = 14;
   localparam int C_DEF_INPORT_WIDTH        = 3;
   localparam int C_DEF_OUTPORT_WIDTH       = 8;
   localparam int C_MAX_INPUTS              = 8;

   // First requesting index after 'last', wrapping modulo 'num'; returns 'last' if none request.
   function automatic logic [2:0] rr_next(input logic [2:0]              last,
                                          input logic [C_MAX_INPUTS-1:0] req,
                                          input int                      num);
      logic [2:0] pick;
      logic [2:0] idx;
      logic       found;
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= C_MAX_INPUTS; i++) begin
         idx = 3'((int'(last) + i) % num);
         if (i <= num && !found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/nf10_upb_axis_reg_slice.sv
// Two-entry skid buffer: full throughput, registered ready toward the source,
// output held stable while stalled.
module nf10_upb_axis_reg_slice #(
   parameter int C_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [C_WIDTH-1:0] s_data,
   input  logic               s_valid,
   output logic               s_ready,
   output logic [C_WIDTH-1:0] m_data,
   output logic               m_valid,
   input  logic               m_ready
);

   logic [C_WIDTH-1:0] main_reg;
   logic [C_WIDTH-1:0] skid_reg;
   logic               main_valid_reg;
   logic               ready_reg;

   // ready_reg low means the skid entry holds a beat waiting behind main_reg.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_reg       <= '0;
         skid_reg       <= '0;
         main_valid_reg <= 1'b0;
         ready_reg      <= 1'b1;
      end else if (ready_reg) begin
         if (!main_valid_reg || m_ready) begin
            main_valid_reg <= s_valid;
            if (s_valid)
               main_reg <= s_data;
         end else if (s_valid) begin
            skid_reg  <= s_data;
            ready_reg <= 1'b0;
         end
      end else if (m_ready) begin
         main_reg  <= skid_reg;
         ready_reg <= 1'b1;
      end
   end

   assign s_ready = ready_reg;
   assign m_data  = main_reg;
   assign m_valid = main_valid_reg;

endmodule

// File: rtl/nf10_upb_packet_arbiter.sv
// Packet-granular round-robin merge of C_NUM_INPUTS AXI4-Stream inputs into one
// stream; a grant is held from the first beat until the tlast beat is accepted.
module nf10_upb_packet_arbiter
   import nf10_upb_pkg::*;
#(
   parameter int C_NUM_INPUTS          = 4,
   parameter int C_AXIS_DATA_WIDTH     = 256,
   parameter int C_PACKET_LENGTH_WIDTH = C_DEF_PACKET_LENGTH_WIDTH,
   parameter int C_INPORT_WIDTH        = C_DEF_INPORT_WIDTH,
   parameter int C_OUTPORT_WIDTH       = C_DEF_OUTPORT_WIDTH
) (
   input  logic                                         axi_aclk,
   input  logic                                         axi_resetn,
   input  logic [C_NUM_INPUTS*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_NUM_INPUTS*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_NUM_INPUTS*C_PACKET_LENGTH_WIDTH-1:0] s_axis_tuser_packet_length,
   input  logic [C_NUM_INPUTS*C_INPORT_WIDTH-1:0]       s_axis_tuser_in_port,
   input  logic [C_NUM_INPUTS*C_OUTPORT_WIDTH-1:0]      s_axis_tuser_out_port,
   input  logic [C_NUM_INPUTS*C_INPORT_WIDTH-1:0]       s_axis_tuser_in_vport,
   input  logic [C_NUM_INPUTS*C_OUTPORT_WIDTH-1:0]      s_axis_tuser_out_vport,
   input  logic [C_NUM_INPUTS-1:0]                      s_axis_tvalid,
   output logic [C_NUM_INPUTS-1:0]                      s_axis_tready,
   input  logic [C_NUM_INPUTS-1:0]                      s_axis_tlast,
   output logic [C_AXIS_DATA_WIDTH-1:0]                 m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]               m_axis_tkeep,
   output logic [C_PACKET_LENGTH_WIDTH-1:0]             m_axis_tuser_packet_length,
   output logic [C_INPORT_WIDTH-1:0]                    m_axis_tuser_in_port,
   output logic [C_OUTPORT_WIDTH-1:0]                   m_axis_tuser_out_port,
   output logic [C_INPORT_WIDTH-1:0]                    m_axis_tuser_in_vport,
   output logic [C_OUTPORT_WIDTH-1:0]                   m_axis_tuser_out_vport,
   output logic                                         m_axis_tvalid,
   input  logic                                         m_axis_tready,
   output logic                                         m_axis_tlast,
   output logic                                         grant_valid,
   output logic [2:0]                                   grant_port
);

   localparam int DW = C_AXIS_DATA_WIDTH;
   localparam int KW = C_AXIS_DATA_WIDTH / 8;
   localparam int BW = DW + KW + C_PACKET_LENGTH_WIDTH + 2*C_INPORT_WIDTH + 2*C_OUTPORT_WIDTH + 1;

   logic [BW-1:0]           in_bus [C_NUM_INPUTS];
   logic [BW-1:0]           sel_bus;
   logic                    sel_valid;
   logic [BW-1:0]           m_bus;
   logic                    slice_valid;
   logic                    slice_ready;
   logic                    accept;
   logic [C_MAX_INPUTS-1:0] req;

   arb_state_t state_reg,       state_next;
   logic [2:0] grant_reg,       grant_next;
   logic [2:0] last_grant_reg,  last_grant_next;
   logic       grant_valid_reg, grant_valid_next;

   // tlast sits in the LSB so the end-of-packet test is sel_bus[0].
   generate
      for (genvar gi = 0; gi < C_NUM_INPUTS; gi++) begin : g_pack
         assign in_bus[gi] = {s_axis_tdata[gi*DW +: DW],
                              s_axis_tkeep[gi*KW +: KW],
                              s_axis_tuser_packet_length[gi*C_PACKET_LENGTH_WIDTH +: C_PACKET_LENGTH_WIDTH],
                              s_axis_tuser_in_port[gi*C_INPORT_WIDTH +: C_INPORT_WIDTH],
                              s_axis_tuser_out_port[gi*C_OUTPORT_WIDTH +: C_OUTPORT_WIDTH],
                              s_axis_tuser_in_vport[gi*C_INPORT_WIDTH +: C_INPORT_WIDTH],
                              s_axis_tuser_out_vport[gi*C_OUTPORT_WIDTH +: C_OUTPORT_WIDTH],
                              s_axis_tlast[gi]};
      end
   endgenerate

   always_comb begin
      req                      = '0;
      req[C_NUM_INPUTS-1:0]    = s_axis_tvalid;
      sel_bus                  = '0;
      sel_valid                = 1'b0;
      s_axis_tready            = '0;
      for (int i = 0; i < C_NUM_INPUTS; i++) begin
         if (grant_reg == 3'(i)) begin
            sel_bus          = in_bus[i];
            sel_valid        = s_axis_tvalid[i];
            s_axis_tready[i] = (state_reg == XFER) && slice_ready;
         end
      end
   end

   assign slice_valid = (state_reg == XFER) && sel_valid;
   assign accept      = slice_valid && slice_ready;

   always_comb begin
      state_next       = state_reg;
      grant_next       = grant_reg;
      last_grant_next  = last_grant_reg;
      grant_valid_next = grant_valid_reg;
      case (state_reg)
         IDLE: begin
            if (|s_axis_tvalid) begin
               grant_next       = rr_next(last_grant_reg, req, C_NUM_INPUTS);
               grant_valid_next = 1'b1;
               state_next       = XFER;
            end
         end
         XFER: begin
            if (accept && sel_bus[0]) begin
               last_grant_next  = grant_reg;
               grant_valid_next = 1'b0;
               state_next       = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // last_grant starts at the top index so input 0 is the first winner.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_reg       <= IDLE;
         grant_reg       <= '0;
         last_grant_reg  <= 3'(C_NUM_INPUTS - 1);
         grant_valid_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         grant_reg       <= grant_next;
         last_grant_reg  <= last_grant_next;
         grant_valid_reg <= grant_valid_next;
      end
   end

   nf10_upb_axis_reg_slice #(
      .C_WIDTH (BW)
   ) u_slice (
      .clk     (axi_aclk),
      .rst_n   (axi_resetn),
      .s_data  (sel_bus),
      .s_valid (slice_valid),
      .s_ready (slice_ready),
      .m_data  (m_bus),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready)
   );

   assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser_packet_length, m_axis_tuser_in_port,
           m_axis_tuser_out_port, m_axis_tuser_in_vport, m_axis_tuser_out_vport,
           m_axis_tlast} = m_bus;

   assign grant_valid = grant_valid_reg;
   assign grant_port  = grant_reg;

endmodule

// File: tb/tb_nf10_upb_packet_arbiter.sv
// Scoreboard bench for nf10_upb_packet_arbiter: drivers feed per-input beat queues,
// a monitor pops expected beats in hand-computed arbitration order.
module tb_nf10_upb_packet_arbiter;

   localparam int N = 4, DW = 256, KW = 32, PLW = 14, IPW = 3, OPW = 8;

   typedef struct packed {
      logic [DW-1:0]  tdata;
      logic [KW-1:0]  tkeep;
      logic [PLW-1:0] plen;
      logic [IPW-1:0] in_port;
      logic [OPW-1:0] out_port;
      logic [IPW-1:0] in_vport;
      logic [OPW-1:0] out_vport;
      logic           last;
   } beat_t;

   logic              clk;
   logic              rst_n;
   logic [N*DW-1:0]   s_tdata;
   logic [N*KW-1:0]   s_tkeep;
   logic [N*PLW-1:0]  s_plen;
   logic [N*IPW-1:0]  s_in_port;
   logic [N*OPW-1:0]  s_out_port;
   logic [N*IPW-1:0]  s_in_vport;
   logic [N*OPW-1:0]  s_out_vport;
   logic [N-1:0]      s_tvalid;
   logic [N-1:0]      s_tready;
   logic [N-1:0]      s_tlast;
   logic [DW-1:0]     m_tdata;
   logic [KW-1:0]     m_tkeep;
   logic [PLW-1:0]    m_plen;
   logic [IPW-1:0]    m_in_port;
   logic [OPW-1:0]    m_out_port;
   logic [IPW-1:0]    m_in_vport;
   logic [OPW-1:0]    m_out_vport;
   logic              m_tvalid;
   logic              m_tready;
   logic              m_tlast;
   logic              grant_valid;
   logic [2:0]        grant_port;

   beat_t src_q [N][$];
   beat_t exp_q [$];
   int    beat_cyc [$];
   logic [N-1:0] hold;
   bit    toggle_mode;
   int    cyc = 0;
   int    total = 0;
   int    bad = 0;

   nf10_upb_packet_arbiter dut (
      .axi_aclk                   (clk),
      .axi_resetn                 (rst_n),
      .s_axis_tdata               (s_tdata),
      .s_axis_tkeep               (s_tkeep),
      .s_axis_tuser_packet_length (s_plen),
      .s_axis_tuser_in_port       (s_in_port),
      .s_axis_tuser_out_port      (s_out_port),
      .s_axis_tuser_in_vport      (s_in_vport),
      .s_axis_tuser_out_vport     (s_out_vport),
      .s_axis_tvalid              (s_tvalid),
      .s_axis_tready              (s_tready),
      .s_axis_tlast               (s_tlast),
      .m_axis_tdata               (m_tdata),
      .m_axis_tkeep               (m_tkeep),
      .m_axis_tuser_packet_length (m_plen),
      .m_axis_tuser_in_port       (m_in_port),
      .m_axis_tuser_out_port      (m_out_port),
      .m_axis_tuser_in_vport      (m_in_vport),
      .m_axis_tuser_out_vport     (m_out_vport),
      .m_axis_tvalid              (m_tvalid),
      .m_axis_tready              (m_tready),
      .m_axis_tlast               (m_tlast),
      .grant_valid                (grant_valid),
      .grant_port                 (grant_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic beat_t mk(int src, int pkt, int b, int nb);
      beat_t t;
      for (int w = 0; w < 8; w++)
         t.tdata[w*32 +: 32] = {8'(src), 8'(pkt), 8'(b), 8'(w)};
      t.tkeep     = (b == nb - 1) ? 32'h0000_ffff : 32'hffff_ffff;
      t.plen      = 14'(nb*32 - 16);
      t.in_port   = 3'(src);
      t.out_port  = 8'(1 << ((src + 1) % 4));
      t.in_vport  = 3'(src + 4);
      t.out_vport = 8'(pkt);
      t.last      = (b == nb - 1);
      return t;
   endfunction

   task automatic send(int src, int pkt, int nb);
      for (int b = 0; b < nb; b++) src_q[src].push_back(mk(src, pkt, b, nb));
   endtask

   task automatic expect_pkt(int src, int pkt, int nb);
      for (int b = 0; b < nb; b++) exp_q.push_back(mk(src, pkt, b, nb));
   endtask

   function automatic bit src_busy();
      bit busy = 1'b0;
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) busy = 1'b1;
      return busy;
   endfunction

   task automatic chk(string name, logic [63:0] got, logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic wait_drain(int budget, string name);
      int n = 0;
      while ((exp_q.size() != 0 || src_busy()) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_drain_left"}, 64'(exp_q.size()), 0);
      exp_q.delete();
      for (int i = 0; i < N; i++) src_q[i].delete();
   endtask

   // Source drivers: a beat leaves its queue once a handshake was seen at the negedge before.
   initial begin
      logic [N-1:0] acc;
      beat_t b;
      s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_plen = '0; s_in_port = '0;
      s_out_port = '0; s_in_vport = '0; s_out_vport = '0; s_tlast = '0; m_tready = 1'b1;
      forever begin
         @(negedge clk);
         acc = s_tvalid & s_tready;
         @(posedge clk);
         #1;
         m_tready = toggle_mode ? ~m_tready : 1'b1;
         for (int i = 0; i < N; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0 && !hold[i]) begin
               b = src_q[i][0];
               s_tdata[i*DW +: DW]       = b.tdata;
               s_tkeep[i*KW +: KW]       = b.tkeep;
               s_plen[i*PLW +: PLW]      = b.plen;
               s_in_port[i*IPW +: IPW]   = b.in_port;
               s_out_port[i*OPW +: OPW]  = b.out_port;
               s_in_vport[i*IPW +: IPW]  = b.in_vport;
               s_out_vport[i*OPW +: OPW] = b.out_vport;
               s_tlast[i]                = b.last;
               s_tvalid[i]               = 1'b1;
            end else begin
               s_tvalid[i] = 1'b0;
            end
         end
      end
   end

   // Monitor: compares every output handshake against the scoreboard and checks stall stability.
   initial begin
      beat_t cur, held, want;
      bit stalled;
      stalled = 1'b0;
      forever begin
         @(negedge clk);
         cur = {m_tdata, m_tkeep, m_plen, m_in_port, m_out_port, m_in_vport, m_out_vport, m_tlast};
         if (!rst_n) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               total++;
               if (!m_tvalid || cur !== held) begin
                  bad++;
                  $display("FAIL hold_stable: got valid=%0b %h want valid=1 %h", m_tvalid, cur, held);
               end
            end
            stalled = 1'b0;
            if (m_tvalid && m_tready) begin
               total++;
               beat_cyc.push_back(cyc);
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_beat: got %h want none", cur);
               end else begin
                  want = exp_q.pop_front();
                  if (cur !== want) begin
                     bad++;
                     $display("FAIL beat: got %h want %h", cur, want);
                  end
               end
               $display("beat cyc=%0d src=%0d pkt=%0d idx=%0d last=%0b grant=%0d",
                        cyc, m_in_port, m_out_vport, m_tdata[15:8], m_tlast, grant_port);
            end else if (m_tvalid) begin
               stalled = 1'b1;
               held    = cur;
            end
         end
      end
   end

   initial begin
      int issue;
      int n;
      rst_n = 1'b0; hold = '0; toggle_mode = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_m_tvalid", 64'(m_tvalid), 0);
      chk("rst_grant_valid", 64'(grant_valid), 0);
      chk("rst_grant_port", 64'(grant_port), 0);
      chk("rst_s_tready", 64'(s_tready), 0);
      chk("rst_m_tdata_any", 64'(|m_tdata), 0);
      rst_n = 1'b1;

      // Test 1: all four inputs at once -> 0,1,2,3 with one output bubble per packet boundary.
      @(negedge clk);
      issue = cyc;
      beat_cyc.delete();
      for (int s = 0; s < N; s++) send(s, 1, 3);
      for (int s = 0; s < N; s++) expect_pkt(s, 1, 3);
      wait_drain(100, "t1");
      chk("t1_beats", 64'(beat_cyc.size()), 12);
      // one cycle of driver setup plus grant cycle plus slice register
      if (beat_cyc.size() >= 12) begin
         chk("t1_latency", 64'(beat_cyc[0] - issue), 3);
         chk("t1_span", 64'(beat_cyc[11] - beat_cyc[0]), 14);
      end

      // Test 2: five back-to-back packets from input 2.
      @(negedge clk);
      for (int p = 0; p < 5; p++) begin
         send(2, 10 + p, 2 + p);
         expect_pkt(2, 10 + p, 2 + p);
      end
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
         if (grant_valid) chk("t2_grant_port", 64'(grant_port), 2);
      end
      wait_drain(10, "t2");

      // Test 3: last_grant=1, inputs 1 (two packets) and 3 waiting -> 3,1,1.
      @(negedge clk);
      send(1, 20, 2);
      expect_pkt(1, 20, 2);
      wait_drain(50, "t3a");
      @(negedge clk);
      send(1, 21, 3);
      send(1, 22, 2);
      send(3, 23, 3);
      expect_pkt(3, 23, 3);
      expect_pkt(1, 21, 3);
      expect_pkt(1, 22, 2);
      n = 0;
      while (!grant_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t3_first_grant", 64'(grant_port), 3);
      wait_drain(100, "t3b");

      // Test 4: 64-beat packet with m_tready toggling every cycle.
      @(negedge clk);
      toggle_mode = 1'b1;
      send(1, 30, 64);
      expect_pkt(1, 30, 64);
      wait_drain(400, "t4");
      toggle_mode = 1'b0;

      // Test 5: granted input 1 stalls 10 cycles mid-packet while input 0 waits.
      @(negedge clk);
      send(1, 40, 4);
      expect_pkt(1, 40, 4);
      n = 0;
      while (!(s_tvalid[1] && s_tready[1] && src_q[1].size() == 3) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t5_reached_beat2", 64'(src_q[1].size()), 3);
      hold[1] = 1'b1;
      send(0, 41, 3);
      expect_pkt(0, 41, 3);
      repeat (10) begin
         @(negedge clk);
         chk("t5_in0_tready", 64'(s_tready[0]), 0);
         chk("t5_grant_port", 64'(grant_port), 1);
      end
      chk("t5_out_idle", 64'(m_tvalid), 0);
      hold[1] = 1'b0;
      wait_drain(60, "t5");

      // Test 6: reset during beat 2 of 4; afterwards input 0 must win over input 3.
      @(negedge clk);
      send(3, 50, 4);
      expect_pkt(3, 50, 4);
      n = 0;
      while (!(s_tvalid[3] && s_tready[3] && src_q[3].size() == 3) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t6_reached_beat2", 64'(src_q[3].size()), 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_m_tvalid", 64'(m_tvalid), 0);
      chk("t6_rst_grant_valid", 64'(grant_valid), 0);
      chk("t6_rst_s_tready", 64'(s_tready), 0);
      exp_q.delete();
      for (int i = 0; i < N; i++) src_q[i].delete();
      hold = '0;
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      send(0, 60, 3);
      send(3, 61, 3);
      expect_pkt(0, 60, 3);
      expect_pkt(3, 61, 3);
      n = 0;
      while (!grant_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t6_first_grant", 64'(grant_port), 0);
      wait_drain(60, "t6");

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
